// File: rtl/aes256_cipher_iter.sv
// Iterative AES-256 encryptor: one round per clock behind a valid/ready handshake.
// The round keys come from the 2048-bit expanded-key bus, which can be latched when a block is accepted.
module aes256_cipher_iter #(
  parameter int NR        = 14,
  parameter bit LATCH_KEY = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2047:0] key_exp,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  plaintext,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  ciphertext,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_e;

  localparam logic [3:0] LAST_MIX = 4'(NR - 1);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) begin
      o[127-8*k -: 8] = sbox(s[127-8*k -: 8]);
    end
    return o;
  endfunction

  // Byte k sits at row k%4, column k/4; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  state_e         state_q, state_d;
  logic [3:0]     rnd_q, rnd_d;
  logic [127:0]   blk_q, blk_d;
  logic [127:0]   ct_q, ct_d;
  logic [2047:0]  key_q, key_d;

  logic [2047:0]  key_cur;
  logic [10:0]    rk_idx;
  logic [127:0]   rk_cur, rk0;
  logic [127:0]   sr_blk;
  logic           accept, retire;

  // Round key r lives at bits [(15-r)*128 +: 128]; rk0 is taken live since the latch happens on the same edge.
  assign key_cur = LATCH_KEY ? key_q : key_exp;
  assign rk_idx  = {4'd15 - rnd_q, 7'd0};
  assign rk_cur  = key_cur[rk_idx +: 128];
  assign rk0     = key_exp[2047 -: 128];
  assign sr_blk  = shift_rows(sub_bytes(blk_q));

  assign in_ready   = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q == ROUND) | (state_q == FINAL);
  assign ciphertext = ct_q;
  assign accept     = in_valid & in_ready;
  assign retire     = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    blk_d   = blk_q;
    ct_d    = ct_q;
    key_d   = key_q;
    case (state_q)
      IDLE: ;
      ROUND: begin
        blk_d = mix_columns(sr_blk) ^ rk_cur;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == LAST_MIX) state_d = FINAL;
      end
      FINAL: begin
        ct_d    = sr_blk ^ rk_cur;
        rnd_d   = 4'd0;
        state_d = DONE;
      end
      DONE: begin
        if (retire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A new block may load in IDLE, or in DONE on the same edge the previous result retires.
    if (accept) begin
      blk_d   = plaintext ^ rk0;
      rnd_d   = 4'd1;
      state_d = ROUND;
      if (LATCH_KEY) key_d = key_exp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rnd_q   <= 4'd0;
      blk_q   <= '0;
      ct_q    <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      blk_q   <= blk_d;
      ct_q    <= ct_d;
      key_q   <= key_d;
    end
  end

endmodule

// File: tb/tb_aes256_cipher_iter.sv
// Directed bench for aes256_cipher_iter with a queue-based scoreboard and an independent monitor.
// The expanded key is produced here from the cipher key using an arithmetic S-box.
module tb_aes256_cipher_iter;

  logic          clk;
  logic          rst;
  logic [2047:0] key_exp;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  plaintext;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  ciphertext;
  logic          busy;

  aes256_cipher_iter #(.NR(14), .LATCH_KEY(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_exp   (key_exp),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .plaintext (plaintext),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ciphertext(ciphertext),
    .busy      (busy)
  );

  localparam logic [255:0] K1  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] C0  = 128'hdc95c078a2408989ad48a21492842087;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int hs_cnt   = 0;
  logic prev_ov = 1'b0;

  logic [127:0] exp_q[$];
  int           lat_q[$];
  int           acc_log[$];
  int           hs_log[$];
  int           rise_log[$];

  logic [2047:0] kx1, kx0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sb(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h00;
    if (a != 8'h00) begin
      for (int i = 1; i < 256; i++) begin
        if (gmul(a, i[7:0]) == 8'h01) inv = i[7:0];
      end
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [2047:0] expand(input logic [255:0] k);
    logic [31:0]   w[60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [2047:0] r;
    for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
      end
      w[i] = w[i-8] ^ t;
    end
    r = '0;
    for (int i = 0; i < 60; i++) r[2047-32*i -: 32] = w[i];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Monitor: latency on each out_valid rise, value on each output handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_ov <= 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        rise_log.push_back(cyc);
        if (lat_q.size() == 0) chk("unexpected_out_valid", 128'(1), 128'(0));
        else chk("latency", 128'(cyc - lat_q.pop_front()), 128'(14));
      end
      if (out_valid && out_ready) begin
        hs_cnt++;
        hs_log.push_back(cyc + 1);
        if (exp_q.size() == 0) chk("unexpected_handshake", 128'(1), 128'(0));
        else chk("ciphertext", ciphertext, exp_q.pop_front());
      end
      prev_ov <= out_valid;
    end
  end

  task automatic send(input logic [2047:0] kx, input logic [127:0] pt, input logic [127:0] ct);
    bit got;
    got       = 1'b0;
    key_exp   = kx;
    plaintext = pt;
    in_valid  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(ct);
        lat_q.push_back(cyc + 1);
        acc_log.push_back(cyc + 1);
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("accept_timeout", 128'(0), 128'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("drain_timeout", 128'(exp_q.size()), 128'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    kx1       = expand(K1);
    kx0       = expand(256'h0);
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    plaintext = '0;
    key_exp   = '0;

    // Reset state
    #2 rst = 1'b1;
    #1;
    chk("rst_ciphertext", ciphertext, 128'h0);
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    #20 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1;

    // FIPS-197 C.3 and all-zero vectors
    send(kx1, P1, C1);
    drain();
    send(kx0, 128'h0, C0);
    drain();

    // Backpressure
    out_ready = 1'b0;
    send(kx1, P1, C1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("bp_out_valid_rose", 128'(out_valid), 128'(1));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_ciphertext_stable", ciphertext, C1);
      chk("bp_in_ready_low", 128'(in_ready), 128'(0));
    end
    @(posedge clk); #1;
    begin
      int hs0;
      hs0 = hs_cnt;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("bp_single_handshake", 128'(hs_cnt - hs0), 128'(1));
      chk("bp_idle_out_valid", 128'(out_valid), 128'(0));
      chk("bp_idle_busy", 128'(busy), 128'(0));
      chk("bp_idle_in_ready", 128'(in_ready), 128'(1));
    end
    @(posedge clk); #1;

    // Back-to-back
    acc_log.delete(); hs_log.delete(); rise_log.delete();
    send(kx1, P1, C1);
    send(kx0, 128'h0, C0);
    drain();
    if (acc_log.size() >= 2 && hs_log.size() >= 1 && rise_log.size() >= 2) begin
      chk("b2b_accept_on_handshake", 128'(acc_log[1]), 128'(hs_log[0]));
      chk("b2b_spacing", 128'(rise_log[1] - rise_log[0]), 128'(15));
    end else begin
      chk("b2b_log_entries", 128'(acc_log.size()), 128'(2));
    end

    // Reset mid-round
    send(kx1, P1, C1);
    repeat (6) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_ciphertext", ciphertext, 128'h0);
    exp_q.delete();
    lat_q.delete();
    #12 rst = 1'b0;
    #1;
    chk("mid_rst_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    send(kx1, P1, C1);
    drain();

    // Key bus change while busy
    send(kx1, P1, C1);
    repeat (2) @(posedge clk);
    #2 key_exp = '1;
    drain();
    key_exp = kx1;

    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
